// File: rtl/decode_stage.sv
// decode_stage: single-entry RV32I decode stage with load-use hazard detection.
// Accepts one instruction per cycle from fetch, decodes it into class, controls,
// immediate and ASCII mnemonic, and holds the result in a registered output slot
// for execute under a valid/ready handshake.
//
// Ports:
//   clock, reset_n      - clock, asynchronous active-low reset
//   in_valid/in_ready   - fetch handshake (in_ready is combinational)
//   in_instr, in_pc     - raw instruction word and its PC
//   flush               - drop held entry, block acceptance this cycle
//   ex_is_load, ex_rd   - execute-stage load info for load-use hazard check
//   out_valid/out_ready - execute handshake
//   out_*               - registered decoded fields, controls and mnemonic
//   stall_cnt           - saturating count of load-use stall cycles
module decode_stage #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned MNEM_EN = 1
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    input  logic            ex_is_load,
    input  logic [4:0]      ex_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_f3,
    output logic            out_f7b5,
    output logic [XLEN-1:0] out_imm,
    output logic [8:0]      out_type,
    output logic            out_alusrc,
    output logic            out_memtoreg,
    output logic            out_regwrite,
    output logic            out_memwrite,
    output logic            out_branch,
    output logic            out_jump,
    output logic            out_illegal,
    output logic [39:0]     out_mnem,
    output logic [15:0]     stall_cnt
);

    localparam int unsigned TW  = 9;
    localparam int unsigned MW  = 40;
    localparam int unsigned SCW = 16;

    // One-hot class bit positions
    localparam int unsigned T_R    = 8;
    localparam int unsigned T_I    = 7;
    localparam int unsigned T_LD   = 6;
    localparam int unsigned T_ST   = 5;
    localparam int unsigned T_BR   = 4;
    localparam int unsigned T_JAL  = 3;
    localparam int unsigned T_LUI  = 2;
    localparam int unsigned T_AUI  = 1;
    localparam int unsigned T_JALR = 0;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    // Instruction fields
    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rs1, rs2, rd;

    assign opcode = in_instr[6:0];
    assign rd     = in_instr[11:7];
    assign f3     = in_instr[14:12];
    assign rs1    = in_instr[19:15];
    assign rs2    = in_instr[24:20];
    assign f7     = in_instr[31:25];

    // Decoder outputs
    logic [TW-1:0]   dec_type;
    logic            dec_bad;
    logic [31:0]     dec_imm32;
    logic [MW-1:0]   dec_mnem;
    logic [XLEN-1:0] dec_imm;
    logic            dec_alusrc, dec_memtoreg, dec_regwrite;
    logic            dec_memwrite, dec_branch, dec_jump;
    logic            uses_rs1, uses_rs2;

    // Class, immediate and mnemonic decode; illegal encodings collapse to "ILL"
    always_comb begin
        dec_type  = '0;
        dec_bad   = 1'b0;
        dec_imm32 = '0;
        dec_mnem  = '0;
        if (in_instr == 32'h0) begin
            dec_mnem = "NOP  ";
        end else begin
            case (opcode)
                OP_LUI: begin
                    dec_type[T_LUI] = 1'b1;
                    dec_imm32       = {in_instr[31:12], 12'h000};
                    dec_mnem        = "LUI  ";
                end
                OP_AUIPC: begin
                    dec_type[T_AUI] = 1'b1;
                    dec_imm32       = {in_instr[31:12], 12'h000};
                    dec_mnem        = "AUIPC";
                end
                OP_JAL: begin
                    dec_type[T_JAL] = 1'b1;
                    dec_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                                 in_instr[20], in_instr[30:21], 1'b0};
                    dec_mnem  = "JAL  ";
                end
                OP_JALR: begin
                    dec_type[T_JALR] = 1'b1;
                    dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
                    dec_mnem  = "JALR ";
                    dec_bad   = (f3 != 3'd0);
                end
                OP_BRANCH: begin
                    dec_type[T_BR] = 1'b1;
                    dec_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                                 in_instr[30:25], in_instr[11:8], 1'b0};
                    case (f3)
                        3'd0:    dec_mnem = "BEQ  ";
                        3'd1:    dec_mnem = "BNE  ";
                        3'd4:    dec_mnem = "BLT  ";
                        3'd5:    dec_mnem = "BGE  ";
                        3'd6:    dec_mnem = "BLTU ";
                        3'd7:    dec_mnem = "BGEU ";
                        default: dec_bad  = 1'b1;
                    endcase
                end
                OP_LOAD: begin
                    dec_type[T_LD] = 1'b1;
                    dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
                    case (f3)
                        3'd0:    dec_mnem = "LB   ";
                        3'd1:    dec_mnem = "LH   ";
                        3'd2:    dec_mnem = "LW   ";
                        3'd4:    dec_mnem = "LBU  ";
                        3'd5:    dec_mnem = "LHU  ";
                        default: dec_bad  = 1'b1;
                    endcase
                end
                OP_STORE: begin
                    dec_type[T_ST] = 1'b1;
                    dec_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
                    case (f3)
                        3'd0:    dec_mnem = "SB   ";
                        3'd1:    dec_mnem = "SH   ";
                        3'd2:    dec_mnem = "SW   ";
                        default: dec_bad  = 1'b1;
                    endcase
                end
                OP_IMM: begin
                    dec_type[T_I] = 1'b1;
                    dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
                    case (f3)
                        3'd0: dec_mnem = "ADDI ";
                        3'd2: dec_mnem = "SLTI ";
                        3'd3: dec_mnem = "SLTIU";
                        3'd4: dec_mnem = "XORI ";
                        3'd6: dec_mnem = "ORI  ";
                        3'd7: dec_mnem = "ANDI ";
                        3'd1: begin
                            dec_mnem = "SLLI ";
                            dec_bad  = (f7 != 7'h00);
                        end
                        default: begin
                            if (f7 == 7'h00)      dec_mnem = "SRLI ";
                            else if (f7 == 7'h20) dec_mnem = "SRAI ";
                            else                  dec_bad  = 1'b1;
                        end
                    endcase
                end
                OP_REG: begin
                    dec_type[T_R] = 1'b1;
                    case ({f7, f3})
                        {7'h00, 3'd0}: dec_mnem = "ADD  ";
                        {7'h20, 3'd0}: dec_mnem = "SUB  ";
                        {7'h00, 3'd1}: dec_mnem = "SLL  ";
                        {7'h00, 3'd2}: dec_mnem = "SLT  ";
                        {7'h00, 3'd3}: dec_mnem = "SLTU ";
                        {7'h00, 3'd4}: dec_mnem = "XOR  ";
                        {7'h00, 3'd5}: dec_mnem = "SRL  ";
                        {7'h20, 3'd5}: dec_mnem = "SRA  ";
                        {7'h00, 3'd6}: dec_mnem = "OR   ";
                        {7'h00, 3'd7}: dec_mnem = "AND  ";
                        default:       dec_bad  = 1'b1;
                    endcase
                end
                default: dec_bad = 1'b1;
            endcase
            if (dec_bad) begin
                dec_type  = '0;
                dec_imm32 = '0;
                dec_mnem  = "ILL  ";
            end
        end
    end

    // Sign-extend the 32-bit immediate to the datapath width
    assign dec_imm = XLEN'($signed(dec_imm32));

    // Controls and register usage derived from the one-hot class
    always_comb begin
        dec_alusrc   = dec_type[T_I] | dec_type[T_LD] | dec_type[T_ST] | dec_type[T_JALR];
        dec_memtoreg = dec_type[T_LD];
        dec_regwrite = dec_type[T_R] | dec_type[T_I] | dec_type[T_LD] | dec_type[T_JAL]
                     | dec_type[T_LUI] | dec_type[T_AUI] | dec_type[T_JALR];
        dec_memwrite = dec_type[T_ST];
        dec_branch   = dec_type[T_BR];
        dec_jump     = dec_type[T_JAL] | dec_type[T_JALR];
        uses_rs1     = dec_type[T_R] | dec_type[T_I] | dec_type[T_LD] | dec_type[T_ST]
                     | dec_type[T_BR] | dec_type[T_JALR];
        uses_rs2     = dec_type[T_R] | dec_type[T_ST] | dec_type[T_BR];
    end

    // Load-use hazard against the instruction currently in execute
    logic hazard;
    logic accept;

    assign hazard = in_valid & ex_is_load & (ex_rd != 5'd0)
                  & ((uses_rs1 & (rs1 == ex_rd)) | (uses_rs2 & (rs2 == ex_rd)));
    assign in_ready = ~flush & ~hazard & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;

    // State registers
    logic            valid_q, valid_d;
    logic [SCW-1:0]  stall_q, stall_d;
    logic [XLEN-1:0] pc_q, imm_q;
    logic [4:0]      rs1_q, rs2_q, rd_q;
    logic [2:0]      f3_q;
    logic            f7b5_q;
    logic [TW-1:0]   type_q;
    logic            alusrc_q, memtoreg_q, regwrite_q, memwrite_q;
    logic            branch_q, jump_q, illegal_q;
    logic [MW-1:0]   mnem_q, mnem_d;

    // Slot occupancy and stall counter next state; flush wins over accept/hold
    always_comb begin
        valid_d = valid_q;
        stall_d = stall_q;
        mnem_d  = (MNEM_EN != 0) ? dec_mnem : '0;
        if (flush)          valid_d = 1'b0;
        else if (accept)    valid_d = 1'b1;
        else if (out_ready) valid_d = 1'b0;
        if (hazard && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q    <= 1'b0;
            stall_q    <= '0;
            pc_q       <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            f3_q       <= '0;
            f7b5_q     <= 1'b0;
            type_q     <= '0;
            alusrc_q   <= 1'b0;
            memtoreg_q <= 1'b0;
            regwrite_q <= 1'b0;
            memwrite_q <= 1'b0;
            branch_q   <= 1'b0;
            jump_q     <= 1'b0;
            illegal_q  <= 1'b0;
            mnem_q     <= '0;
        end else begin
            valid_q <= valid_d;
            stall_q <= stall_d;
            if (accept) begin
                pc_q       <= in_pc;
                imm_q      <= dec_imm;
                rs1_q      <= rs1;
                rs2_q      <= rs2;
                rd_q       <= rd;
                f3_q       <= f3;
                f7b5_q     <= in_instr[30];
                type_q     <= dec_type;
                alusrc_q   <= dec_alusrc;
                memtoreg_q <= dec_memtoreg;
                regwrite_q <= dec_regwrite;
                memwrite_q <= dec_memwrite;
                branch_q   <= dec_branch;
                jump_q     <= dec_jump;
                illegal_q  <= dec_bad;
                mnem_q     <= mnem_d;
            end
        end
    end

    assign out_valid    = valid_q;
    assign stall_cnt    = stall_q;
    assign out_pc       = pc_q;
    assign out_imm      = imm_q;
    assign out_rs1      = rs1_q;
    assign out_rs2      = rs2_q;
    assign out_rd       = rd_q;
    assign out_f3       = f3_q;
    assign out_f7b5     = f7b5_q;
    assign out_type     = type_q;
    assign out_alusrc   = alusrc_q;
    assign out_memtoreg = memtoreg_q;
    assign out_regwrite = regwrite_q;
    assign out_memwrite = memwrite_q;
    assign out_branch   = branch_q;
    assign out_jump     = jump_q;
    assign out_illegal  = illegal_q;
    assign out_mnem     = mnem_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed-vector bench for decode_stage with hand-computed expectations.
module tb_decode_stage;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        ex_is_load;
    logic [4:0]  ex_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [2:0]  out_f3;
    logic        out_f7b5;
    logic [31:0] out_imm;
    logic [8:0]  out_type;
    logic        out_alusrc, out_memtoreg, out_regwrite, out_memwrite;
    logic        out_branch, out_jump, out_illegal;
    logic [39:0] out_mnem;
    logic [15:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    decode_stage #(.XLEN(32), .MNEM_EN(1)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .flush        (flush),
        .ex_is_load   (ex_is_load),
        .ex_rd        (ex_rd),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_rs1      (out_rs1),
        .out_rs2      (out_rs2),
        .out_rd       (out_rd),
        .out_f3       (out_f3),
        .out_f7b5     (out_f7b5),
        .out_imm      (out_imm),
        .out_type     (out_type),
        .out_alusrc   (out_alusrc),
        .out_memtoreg (out_memtoreg),
        .out_regwrite (out_regwrite),
        .out_memwrite (out_memwrite),
        .out_branch   (out_branch),
        .out_jump     (out_jump),
        .out_illegal  (out_illegal),
        .out_mnem     (out_mnem),
        .stall_cnt    (stall_cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Present one instruction for a single edge, then drop in_valid
    task automatic send(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        cyc();
        in_valid = 1'b0;
    endtask

    initial begin
        reset_n    = 1'b0;
        in_valid   = 1'b0;
        in_instr   = '0;
        in_pc      = '0;
        flush      = 1'b0;
        ex_is_load = 1'b0;
        ex_rd      = '0;
        out_ready  = 1'b0;

        // Reset state
        #12;
        chk("rst_valid", 64'(out_valid), 64'h0);
        chk("rst_stall", 64'(stall_cnt), 64'h0);
        chk("rst_mnem",  64'(out_mnem),  64'h0);
        chk("rst_type",  64'(out_type),  64'h0);
        chk("rst_ready", 64'(in_ready),  64'h1);
        #10 reset_n = 1'b1;

        // addi x1,x0,5
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'h0050_0093;
        in_pc     = 32'h0000_0100;
        @(negedge clock);
        chk("addi_ready", 64'(in_ready), 64'h1);
        cyc();
        in_valid = 1'b0;
        chk("addi_valid",  64'(out_valid),    64'h1);
        chk("addi_type",   64'(out_type),     64'h080);
        chk("addi_imm",    64'(out_imm),      64'h5);
        chk("addi_rd",     64'(out_rd),       64'h1);
        chk("addi_pc",     64'(out_pc),       64'h100);
        chk("addi_rw",     64'(out_regwrite), 64'h1);
        chk("addi_alusrc", 64'(out_alusrc),   64'h1);
        chk("addi_mnem",   64'(out_mnem),     64'("ADDI "));

        // beq x0,x0,-4
        send(32'hFE00_0EE3, 32'h0000_0104);
        chk("beq_imm",    64'(out_imm),      64'hFFFF_FFFC);
        chk("beq_type",   64'(out_type),     64'h010);
        chk("beq_branch", 64'(out_branch),   64'h1);
        chk("beq_rw",     64'(out_regwrite), 64'h0);
        chk("beq_mnem",   64'(out_mnem),     64'("BEQ  "));

        // Load-use hazard: add x3,x1,x2 behind a load to x1
        ex_is_load = 1'b1;
        ex_rd      = 5'd1;
        in_valid   = 1'b1;
        in_instr   = 32'h0020_81B3;
        in_pc      = 32'h0000_0108;
        @(negedge clock);
        chk("haz_ready", 64'(in_ready), 64'h0);
        cyc();
        chk("haz_bubble", 64'(out_valid), 64'h0);
        cyc();
        cyc();
        chk("haz_valid3", 64'(out_valid), 64'h0);
        chk("haz_stall3", 64'(stall_cnt), 64'h3);
        ex_rd = 5'd0;
        @(negedge clock);
        chk("nohaz_ready", 64'(in_ready), 64'h1);
        cyc();
        in_valid = 1'b0;
        chk("add_valid", 64'(out_valid), 64'h1);
        chk("add_mnem",  64'(out_mnem),  64'("ADD  "));
        chk("add_regs",  64'({out_rs1, out_rs2, out_rd}), 64'({5'd1, 5'd2, 5'd3}));
        chk("add_type",  64'(out_type),  64'h100);
        chk("add_stall", 64'(stall_cnt), 64'h3);
        ex_is_load = 1'b0;

        // Backpressure: lui x5,0x12345 waits behind a held entry
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h1234_52B7;
        in_pc     = 32'h0000_010C;
        @(negedge clock);
        chk("bp_ready", 64'(in_ready), 64'h0);
        cyc();
        chk("bp_valid", 64'(out_valid), 64'h1);
        chk("bp_mnem",  64'(out_mnem),  64'("ADD  "));
        chk("bp_rd",    64'(out_rd),    64'h3);
        chk("bp_pc",    64'(out_pc),    64'h108);
        out_ready = 1'b1;
        @(negedge clock);
        chk("bp_ready1", 64'(in_ready), 64'h1);
        cyc();
        in_valid = 1'b0;
        chk("lui_mnem", 64'(out_mnem), 64'("LUI  "));
        chk("lui_imm",  64'(out_imm),  64'h1234_5000);
        chk("lui_type", 64'(out_type), 64'h004);
        chk("lui_rd",   64'(out_rd),   64'h5);

        // Illegal opcode
        send(32'h0000_007F, 32'h0000_0110);
        chk("ill_flag", 64'(out_illegal),  64'h1);
        chk("ill_type", 64'(out_type),     64'h0);
        chk("ill_rw",   64'(out_regwrite), 64'h0);
        chk("ill_mnem", 64'(out_mnem),     64'("ILL  "));

        // Flush kills the held entry
        out_ready = 1'b0;
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'h0050_0093;
        @(negedge clock);
        chk("fl_ready", 64'(in_ready), 64'h0);
        cyc();
        chk("fl_valid", 64'(out_valid), 64'h0);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;

        // sw x2,8(x1)
        send(32'h0020_A423, 32'h0000_0114);
        chk("sw_imm",  64'(out_imm),  64'h8);
        chk("sw_type", 64'(out_type), 64'h020);
        chk("sw_ctl",  64'({out_memwrite, out_alusrc, out_regwrite, out_memtoreg}), 64'hC);
        chk("sw_mnem", 64'(out_mnem), 64'("SW   "));

        // jal x1,16
        send(32'h0100_00EF, 32'h0000_0118);
        chk("jal_imm",  64'(out_imm),  64'h10);
        chk("jal_type", 64'(out_type), 64'h008);
        chk("jal_ctl",  64'({out_jump, out_regwrite, out_branch}), 64'h6);
        chk("jal_mnem", 64'(out_mnem), 64'("JAL  "));

        // Drain with no new accept
        cyc();
        chk("drain_valid", 64'(out_valid), 64'h0);

        // NOP
        send(32'h0000_0000, 32'h0000_011C);
        chk("nop_valid", 64'(out_valid),   64'h1);
        chk("nop_type",  64'(out_type),    64'h0);
        chk("nop_ill",   64'(out_illegal), 64'h0);
        chk("nop_rw",    64'(out_regwrite),64'h0);
        chk("nop_mnem",  64'(out_mnem),    64'("NOP  "));

        // Asynchronous reset between edges while holding an entry
        out_ready = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'h0);
        chk("arst_stall", 64'(stall_cnt), 64'h0);
        chk("arst_mnem",  64'(out_mnem),  64'h0);
        #1 reset_n = 1'b1;

        // First edge after reset accepts
        out_ready = 1'b1;
        send(32'h0050_0093, 32'h0000_0200);
        chk("post_valid", 64'(out_valid), 64'h1);
        chk("post_mnem",  64'(out_mnem),  64'("ADDI "));
        chk("post_pc",    64'(out_pc),    64'h200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
